hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard and forwarding selector for the pipelined RV32 core, sitting beside the decode stage. It tracks in-flight register writes with per-register pending counters, so any number of pipeline stages may hold results. Each decode read port gets either a forwarded value from the youngest matching producer or a stall request. It replaces the fixed three-slot forwarding compare with a generalised, stateful unit that supports flush, saturation back-pressure and error reporting.

## Interface

- REG_COUNT, 32: architectural registers; register 0 is hard-wired zero.
- READ_PORTS, 2: decode read ports.
- FWD_SOURCES, 3: forwarding sources; index 0 is youngest (execute out), higher indices are older.
- MAX_PENDING, 3: maximum in-flight writes per register; CNT_W = $clog2(MAX_PENDING+1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  an instruction leaves decode this cycle.
- issue_we  in  1  the issued instruction writes issue_rd.
- issue_rd  in  5  destination register of the issued instruction.
- issue_ready  out  1  issue is accepted; low when issue_rd's counter equals MAX_PENDING.
- retire_valid  in  1  a register write commits in writeback this cycle.
- retire_rd  in  5  register being committed.
- flush  in  1  pipeline flush; all pending writes are discarded.
- rd_addr  in  READ_PORTS*5  decode read addresses.
- fwd_target  in  FWD_SOURCES*5  per-source destination register.
- fwd_value  in  FWD_SOURCES*32  per-source result data.
- fwd_valid  in  FWD_SOURCES  per-source data valid (low for a load still in execute).
- fwd_active  in  FWD_SOURCES  the source stage holds a valid writing instruction.
- rd_fwd  out  READ_PORTS  forward instead of reading the register file.
- rd_fwd_value  out  READ_PORTS*32  forwarded data; 0 when rd_fwd is low.
- rd_stall  out  READ_PORTS  the operand is not yet available.
- stall  out  1  OR of rd_stall.
- pending_total  out  $clog2(REG_COUNT*MAX_PENDING+1)  sum of all counters.
- error  out  1  sticky: a retire arrived for a register whose counter was 0.

## Operation

- State: one CNT_W counter per register, 1..REG_COUNT-1, plus the error flag. Register 0 has no counter and is never pending.
- Issue: when issue_valid && issue_we && issue_ready && issue_rd != 0, that counter increments by 1.
- Retire: when retire_valid && retire_rd != 0, that counter decrements by 1.
  - If the counter is already 0, it stays 0 and error is set.
- Issue and retire to the same register in the same cycle: the counter is unchanged and error is not set, even if the count is 0.
- Flush: all counters clear to 0 on the next edge. Issue and retire in the same cycle are ignored. error is not cleared.
- issue_ready: low only when issue_we && issue_rd != 0 && count[issue_rd] == MAX_PENDING. A same-cycle retire does not raise it.
- Read port p, with addr = rd_addr[p]:
  - addr == 0 or count[addr] == 0: rd_fwd = 0, rd_stall = 0.
  - Otherwise, find the lowest-index source s with fwd_active[s] && fwd_target[s] == addr.
    - s exists and fwd_valid[s] = 1: rd_fwd = 1, rd_fwd_value = fwd_value[s], rd_stall = 0.
    - s exists and fwd_valid[s] = 0: rd_stall = 1.
    - No s exists: rd_stall = 1 (the producer is in a stage that does not forward yet).
- An older valid match never overrides a younger invalid one.
- pending_total is combinational from the counters.

## Timing

- Reset, asynchronous: all counters 0, error 0, so issue_ready = 1, stall = 0, rd_fwd = 0, rd_fwd_value = 0, pending_total = 0.
- Reset deasserts synchronously to clk via the standard reset synchroniser outside this block.
- Reset mid-operation discards all pending state immediately.
- rd_fwd, rd_fwd_value, rd_stall, stall and issue_ready are combinational from inputs and current counters. There are no registered outputs except state.
- An issue in cycle N becomes visible to reads in cycle N+1. A retire in cycle N clears pending in N+1.
  - In cycle N itself, writeback data reaches readers through the forwarding source for writeback.
- Counter arithmetic saturates at MAX_PENDING because issue is gated. It never wraps below 0.

## Test plan

- Reset, then read x5 with nothing pending -> rd_fwd = 0, rd_stall = 0, pending_total = 0.
- Issue rd = x5 twice (count 2). Source 0 = {x5, 0xDEADBEEF, valid = 1}, source 2 = {x5, 0x1, valid = 1} -> rd_fwd = 1, rd_fwd_value = 0xDEADBEEF.
- x5 pending, source 0 = {x5, valid = 0}, source 1 = {x5, 0x22, valid = 1} -> rd_stall = 1 and stall = 1.
- Issue x7 three times (MAX_PENDING = 3) -> issue_ready = 0 for x7 and 1 for x8. Retire x7 -> next cycle issue_ready = 1.
- Retire x9 with count 0 -> error = 1, and it stays 1 after flush. Simultaneous issue and retire of x9 -> count stays 0, error unchanged.
- Pend x3, x4 and x6, then flush together with retire_valid on x3 -> next cycle pending_total = 0. Assert rst_n low mid-sequence -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and forwarding selector beside decode: per-register pending
// counters, youngest-match operand forwarding, stall generation and sticky error reporting.
module hazard_scoreboard #(
  parameter int REG_COUNT   = 32,
  parameter int READ_PORTS  = 2,
  parameter int FWD_SOURCES = 3,
  parameter int MAX_PENDING = 3,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1),
  localparam int PT_W       = $clog2(REG_COUNT * MAX_PENDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic [4:0]                  issue_rd,
  output logic                        issue_ready,
  input  logic                        retire_valid,
  input  logic [4:0]                  retire_rd,
  input  logic                        flush,
  input  logic [READ_PORTS*5-1:0]     rd_addr,
  input  logic [FWD_SOURCES*5-1:0]    fwd_target,
  input  logic [FWD_SOURCES*32-1:0]   fwd_value,
  input  logic [FWD_SOURCES-1:0]      fwd_valid,
  input  logic [FWD_SOURCES-1:0]      fwd_active,
  output logic [READ_PORTS-1:0]       rd_fwd,
  output logic [READ_PORTS*32-1:0]    rd_fwd_value,
  output logic [READ_PORTS-1:0]       rd_stall,
  output logic                        stall,
  output logic [PT_W-1:0]             pending_total,
  output logic                        error
);

  localparam int AW = 5;

  logic [CNT_W-1:0] count_q  [1:REG_COUNT-1];
  logic [CNT_W-1:0] count_d  [1:REG_COUNT-1];
  logic [CNT_W-1:0] cnt_view [REG_COUNT];
  logic             error_q, error_d;
  logic             issue_fire;
  logic [REG_COUNT-1:0] inc_vec, dec_vec;

  // Register 0 reads as a counter that is permanently zero.
  always_comb begin
    cnt_view[0] = '0;
    for (int r = 1; r < REG_COUNT; r++) cnt_view[r] = count_q[r];
  end

  assign issue_ready = !(issue_we && (issue_rd != '0) &&
                         (cnt_view[issue_rd] == CNT_W'(MAX_PENDING)));
  assign issue_fire  = issue_valid && issue_we && issue_ready && (issue_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      inc_vec[r] = issue_fire && (issue_rd == AW'(r));
      dec_vec[r] = retire_valid && (retire_rd == AW'(r));
    end
  end

  // NOTE: every variable gets a default at the top of the block so no latch is inferred.
  always_comb begin
    error_d = error_q;
    for (int r = 1; r < REG_COUNT; r++) count_d[r] = count_q[r];
    if (flush) begin
      for (int r = 1; r < REG_COUNT; r++) count_d[r] = '0;
    end else begin
      for (int r = 1; r < REG_COUNT; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          count_d[r] = count_q[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (count_q[r] == '0) error_d = 1'b1;
          else                  count_d[r] = count_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the counter array is reset, unlike a data RAM, because pending state must vanish on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < REG_COUNT; r++) count_q[r] <= '0;
      error_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments; the combinational blocks use blocking.
      for (int r = 1; r < REG_COUNT; r++) count_q[r] <= count_d[r];
      error_q <= error_d;
    end
  end

  assign error = error_q;

  always_comb begin
    pending_total = '0;
    for (int r = 1; r < REG_COUNT; r++) pending_total = pending_total + PT_W'(count_q[r]);
  end

  // Youngest active match decides; an older valid match never overrides it.
  logic [AW-1:0] addr;
  logic          found;
  always_comb begin
    rd_fwd       = '0;
    rd_fwd_value = '0;
    rd_stall     = '0;
    addr         = '0;
    found        = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr  = rd_addr[p*AW +: AW];
      found = 1'b0;
      if ((addr != '0) && (cnt_view[addr] != '0)) begin
        for (int s = 0; s < FWD_SOURCES; s++) begin
          if (!found && fwd_active[s] && (fwd_target[s*AW +: AW] == addr)) begin
            found = 1'b1;
            if (fwd_valid[s]) begin
              rd_fwd[p]                = 1'b1;
              rd_fwd_value[p*32 +: 32] = fwd_value[s*32 +: 32];
            end else begin
              rd_stall[p] = 1'b1;
            end
          end
        end
        if (!found) rd_stall[p] = 1'b1;
      end
    end
  end

  assign stall = |rd_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard: a driver pushes expected
// responses from a reference model into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int MAXP = 3;
  localparam int PT_W = $clog2(32 * MAXP + 1);

  typedef struct packed {
    logic            issue_valid;
    logic            issue_we;
    logic [4:0]      issue_rd;
    logic            retire_valid;
    logic [4:0]      retire_rd;
    logic            flush;
    logic [1:0][4:0]  rd_addr;
    logic [2:0][4:0]  tgt;
    logic [2:0][31:0] val;
    logic [2:0]      fv;
    logic [2:0]      fa;
  } stim_t;

  typedef struct packed {
    logic [1:0]       fwd;
    logic [1:0][31:0] fval;
    logic [1:0]       rstall;
    logic             stall;
    logic             ready;
    logic [PT_W-1:0]  ptotal;
    logic             err;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic issue_valid, issue_we, retire_valid, flush, issue_ready, stall, error;
  logic [4:0] issue_rd, retire_rd;
  logic [9:0] rd_addr;
  logic [14:0] fwd_target;
  logic [95:0] fwd_value;
  logic [2:0] fwd_valid, fwd_active;
  logic [1:0] rd_fwd, rd_stall;
  logic [63:0] rd_fwd_value;
  logic [PT_W-1:0] pending_total;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
    .rd_addr(rd_addr), .fwd_target(fwd_target), .fwd_value(fwd_value),
    .fwd_valid(fwd_valid), .fwd_active(fwd_active),
    .rd_fwd(rd_fwd), .rd_fwd_value(rd_fwd_value), .rd_stall(rd_stall),
    .stall(stall), .pending_total(pending_total), .error(error)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   model_cnt [32];
  bit   model_err;
  stim_t cur;
  exp_t  exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_clear();
    foreach (model_cnt[i]) model_cnt[i] = 0;
  endfunction

  // Applies the rules for one clock edge to the register counts.
  function automatic void model_commit(stim_t s);
    bit fire, ret;
    if (s.flush) begin
      model_clear();
      return;
    end
    fire = s.issue_valid && s.issue_we && s.issue_rd != 0 && model_cnt[s.issue_rd] < MAXP;
    ret  = s.retire_valid && s.retire_rd != 0;
    if (fire && ret && s.issue_rd == s.retire_rd) return;
    if (fire) model_cnt[s.issue_rd]++;
    if (ret) begin
      if (model_cnt[s.retire_rd] == 0) model_err = 1;
      else model_cnt[s.retire_rd]--;
    end
  endfunction

  function automatic exp_t model_expect(stim_t s);
    exp_t e;
    int   hit, sum;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      if (s.rd_addr[p] != 0 && model_cnt[s.rd_addr[p]] > 0) begin
        hit = -1;
        for (int k = 0; k < 3; k++)
          if (hit < 0 && s.fa[k] && s.tgt[k] == s.rd_addr[p]) hit = k;
        if (hit >= 0 && s.fv[hit]) begin
          e.fwd[p]  = 1;
          e.fval[p] = s.val[hit];
        end else begin
          e.rstall[p] = 1;
        end
      end
    end
    e.stall = |e.rstall;
    e.ready = !(s.issue_we && s.issue_rd != 0 && model_cnt[s.issue_rd] == MAXP);
    sum = 0;
    foreach (model_cnt[i]) sum += model_cnt[i];
    e.ptotal = PT_W'(sum);
    e.err = model_err;
    return e;
  endfunction

  task automatic apply(stim_t s);
    cur          = s;
    issue_valid  = s.issue_valid;
    issue_we     = s.issue_we;
    issue_rd     = s.issue_rd;
    retire_valid = s.retire_valid;
    retire_rd    = s.retire_rd;
    flush        = s.flush;
    rd_addr      = s.rd_addr;
    fwd_target   = s.tgt;
    fwd_value    = s.val;
    fwd_valid    = s.fv;
    fwd_active   = s.fa;
  endtask

  task automatic step(stim_t s);
    @(posedge clk);
    if (rst_n) model_commit(cur);
    #1;
    apply(s);
    exp_q.push_back(model_expect(s));
  endtask

  // Asserts reset between edges; outputs must reach reset values before the next edge.
  task automatic reset_assert(stim_t s);
    @(posedge clk);
    if (rst_n) model_commit(cur);
    #1;
    rst_n = 0;
    model_clear();
    model_err = 0;
    apply(s);
    exp_q.push_back(model_expect(s));
  endtask

  task automatic reset_release(stim_t s);
    @(posedge clk);
    #1;
    rst_n = 1;
    apply(s);
    exp_q.push_back(model_expect(s));
  endtask

  function automatic stim_t idle();
    return '0;
  endfunction

  function automatic stim_t issue_of(logic [4:0] r);
    stim_t s = '0;
    s.issue_valid = 1; s.issue_we = 1; s.issue_rd = r;
    return s;
  endfunction

  function automatic stim_t retire_of(logic [4:0] r);
    stim_t s = '0;
    s.retire_valid = 1; s.retire_rd = r;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.issue_valid  = ($urandom_range(0, 9) < 6);
    s.issue_we     = ($urandom_range(0, 9) < 8);
    s.issue_rd     = 5'($urandom_range(0, 7));
    s.retire_valid = ($urandom_range(0, 9) < 4);
    s.retire_rd    = 5'($urandom_range(0, 7));
    s.flush        = ($urandom_range(0, 49) == 0);
    for (int p = 0; p < 2; p++) s.rd_addr[p] = 5'($urandom_range(0, 7));
    for (int k = 0; k < 3; k++) begin
      s.tgt[k] = 5'($urandom_range(0, 7));
      s.val[k] = $urandom;
    end
    s.fv = 3'($urandom);
    s.fa = 3'($urandom);
    return s;
  endfunction

  // Monitor: outputs are combinational, so each queued expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_fwd", 64'(rd_fwd), 64'(e.fwd));
        check("rd_fwd_value", rd_fwd_value, e.fval);
        check("rd_stall", 64'(rd_stall), 64'(e.rstall));
        check("stall", 64'(stall), 64'(e.stall));
        check("issue_ready", 64'(issue_ready), 64'(e.ready));
        check("pending_total", 64'(pending_total), 64'(e.ptotal));
        check("error", 64'(error), 64'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    model_clear();
    model_err = 0;
    apply(idle());
    repeat (3) @(posedge clk);
    reset_release(idle());

    // Nothing pending: reads of x5 go to the register file.
    s = idle(); s.rd_addr[0] = 5;
    step(s);

    // Youngest valid match wins over an older one.
    step(issue_of(5));
    step(issue_of(5));
    s = idle(); s.rd_addr[0] = 5; s.rd_addr[1] = 5;
    s.tgt[0] = 5; s.val[0] = 32'hDEADBEEF; s.fv[0] = 1; s.fa[0] = 1;
    s.tgt[2] = 5; s.val[2] = 32'h1;        s.fv[2] = 1; s.fa[2] = 1;
    step(s);

    // Younger invalid match stalls despite an older valid one.
    s = idle(); s.rd_addr[1] = 5;
    s.tgt[0] = 5; s.fv[0] = 0; s.fa[0] = 1;
    s.tgt[1] = 5; s.val[1] = 32'h22; s.fv[1] = 1; s.fa[1] = 1;
    step(s);
    // Pending but no forwarding source holds it.
    s = idle(); s.rd_addr[0] = 5;
    step(s);

    // Saturation back-pressure on x7.
    repeat (3) step(issue_of(7));
    s = issue_of(7); s.issue_valid = 0;
    step(s);
    s.issue_rd = 8;
    step(s);
    step(retire_of(7));
    s.issue_rd = 7;
    step(s);
    step(issue_of(7));
    s = issue_of(7);
    step(s);  // rejected: count already at MAX

    // Retire with nothing pending sets the sticky error; flush keeps it.
    step(retire_of(9));
    s = idle(); s.flush = 1;
    step(s);
    step(idle());
    s = issue_of(9); s.retire_valid = 1; s.retire_rd = 9;
    step(s);
    step(idle());

    // Flush wins over a same-cycle retire.
    step(issue_of(3));
    step(issue_of(4));
    step(issue_of(6));
    s = retire_of(3); s.flush = 1;
    step(s);
    step(idle());

    // Mid-operation reset discards pending state immediately.
    step(issue_of(5));
    step(issue_of(5));
    s = idle(); s.rd_addr[0] = 5; s.tgt[0] = 5; s.fa[0] = 1; s.fv[0] = 1; s.val[0] = 32'h55;
    step(s);
    reset_assert(s);
    reset_release(s);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset_assert(rand_stim());
        reset_release(rand_stim());
      end
      step(rand_stim());
    end
    step(idle());

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
